fetch_stage: RTL and testbench

- Instruction fetch stage with a small prefetch queue, directly upstream of the register/decode stage.
- Generates sequential PCs and issues word fetches on the shared memory port; the bus arbiter grants the port when the data stage is not using it.
- Buffers returned instructions with their PC and PC+4, and presents them to decode under a valid/ready handshake.
- Handles taken branches and jumps from the ALU stage by flushing the queue and discarding in-flight responses.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_stage_if.sv | 13 +
 rtl/fetch_stage_fifo.sv | 45 ++++
 rtl/fetch_stage.sv | 70 +++++++
 tb/tb_fetch_stage.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-path types and constants
// Provides XLEN, the canonical NOP, the fetch entry {pc, instr} and a word-align helper.
package riscv_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction memory port between fetch stage and bus arbiter
// master (fetch): drives imem_req/imem_addr, receives imem_gnt/imem_rvalid/imem_rdata.
// slave (memory): the mirror image.
interface fetch_stage_if;
   import riscv_pkg::*;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;
   modport master(output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
   modport slave(input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_stage_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries
// Ports: clk, reset, push/wdata (enqueue), pop (dequeue head), flush (clear, wins over push/pop),
// head (current head entry, combinational), count (0..DEPTH).
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  fetch_entry_t  wdata,
   input  logic          pop,
   input  logic          flush,
   output fetch_entry_t  head,
   output logic [CW-1:0] count
);
   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      rd_d  = flush ? '0 : pop ? rd_q + 1'b1 : rd_q;
      wr_d  = flush ? '0 : push ? wr_q + 1'b1 : wr_q;
      cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end
   // Storage needs no reset: entries are only visible once count covers them.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_q] <= wdata;
   end
   assign head  = mem_q[rd_q];
   assign count = cnt_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with prefetch queue, credit-limited requests and redirect flush
// Ports: clk, reset (sync, active-high); redirect/redirect_pc from ALU; id_ready from decode;
// imem (master modport) to the shared memory port; if_valid/if_instr/if_pc/if_pc_plus_4 to decode.
module fetch_stage #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 redirect,
   input  logic [31:0]          redirect_pc,
   input  logic                 id_ready,
   fetch_stage_if.master        imem,
   output logic                 if_valid,
   output logic [31:0]          if_instr,
   output logic [31:0]          if_pc,
   output logic [31:0]          if_pc_plus_4
);
   import riscv_pkg::*;
   localparam int CW = $clog2(DEPTH + 1);
   logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
   logic [CW-1:0] out_q, out_d, drop_q, drop_d, count;
   logic          gnt, rsp, push, pop;
   fetch_entry_t  head;
   // In-flight plus buffered fetches never exceed DEPTH, so a returning word always has a slot.
   assign imem.imem_req  = !reset && !redirect && (({1'b0, out_q} + {1'b0, count}) < (CW + 1)'(DEPTH));
   assign imem.imem_addr = fetch_pc_q;
   assign target = word_align(redirect_pc);
   assign gnt    = imem.imem_req && imem.imem_gnt;
   // rvalid with nothing outstanding is a leftover from before reset.
   assign rsp    = imem.imem_rvalid && (out_q != '0);
   assign push   = rsp && (drop_q == '0) && !redirect;
   assign pop    = if_valid && id_ready && !redirect;
   always_comb begin
      out_d      = out_q + CW'(gnt) - CW'(rsp);
      // On redirect every response still owed (minus one landing now) belongs to the old path.
      drop_d     = redirect ? out_q - CW'(rsp) : (rsp && drop_q != '0) ? drop_q - 1'b1 : drop_q;
      fetch_pc_d = redirect ? target : gnt ? fetch_pc_q + 32'd4 : fetch_pc_q;
      resp_pc_d  = redirect ? target : push ? resp_pc_q + 32'd4 : resp_pc_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         out_q      <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
      end
   end
   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata ('{pc: resp_pc_q, instr: imem.imem_rdata}),
      .pop   (pop),
      .flush (redirect),
      .head  (head),
      .count (count)
   );
   // With an empty queue the PC shown is the next one expected back.
   assign if_valid     = count != '0;
   assign if_instr     = if_valid ? head.instr : NOP_INSTR;
   assign if_pc        = if_valid ? head.pc : resp_pc_q;
   assign if_pc_plus_4 = if_pc + 32'd4;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a queue-based model
module tb_fetch_stage;
   import riscv_pkg::*;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] MAGIC    = 32'hA5A5_0000;
   logic        clk = 1'b0;
   logic        reset, redirect, id_ready;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_instr, if_pc, if_pc_plus_4;
   fetch_stage_if imem();
   fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk          (clk),
      .reset        (reset),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .id_ready     (id_ready),
      .imem         (imem),
      .if_valid     (if_valid),
      .if_instr     (if_instr),
      .if_pc        (if_pc),
      .if_pc_plus_4 (if_pc_plus_4)
   );
   always #5 clk = ~clk;
   typedef struct {logic [31:0] a; bit stale;} fl_t;
   typedef struct {logic [31:0] a; int due;} mr_t;
   fl_t          inf[$];
   fetch_entry_t fifo_m[$];
   mr_t          memq[$];
   int           checks, failures, cyc, lat_lo, lat_hi;
   logic [31:0]  m_pc;
   logic         o_req, o_valid;
   logic [31:0]  o_addr, o_instr, o_pc, o_pc4;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic cycle();
      logic        e_req, gr, resp, rv;
      logic [31:0] rd;
      fl_t         x;
      rv = memq.size() != 0 && memq[0].due <= cyc;
      rd = rv ? memq[0].a ^ MAGIC : $urandom;
      imem.imem_rvalid = rv;
      imem.imem_rdata  = rd;
      @(negedge clk);
      o_req = imem.imem_req; o_addr = imem.imem_addr; o_valid = if_valid;
      o_instr = if_instr; o_pc = if_pc; o_pc4 = if_pc_plus_4;
      e_req = !reset && !redirect && (inf.size() + fifo_m.size() < DEPTH);
      chk("req", 32'(o_req), 32'(e_req));
      if (e_req) chk("addr", o_addr, m_pc);
      chk("valid", 32'(o_valid), 32'(fifo_m.size() != 0));
      chk("instr", o_instr, fifo_m.size() != 0 ? fifo_m[0].instr : NOP_INSTR);
      if (fifo_m.size() != 0) begin
         chk("pc", o_pc, fifo_m[0].pc);
         chk("pc4", o_pc4, fifo_m[0].pc + 32'd4);
      end
      @(posedge clk);
      gr   = e_req && imem.imem_gnt;
      resp = rv && inf.size() != 0;
      if (reset) begin
         inf.delete();
         fifo_m.delete();
         m_pc = RESET_PC;
      end else begin
         if (fifo_m.size() != 0 && id_ready && !redirect) void'(fifo_m.pop_front());
         if (resp) begin
            x = inf.pop_front();
            if (!x.stale && !redirect) fifo_m.push_back('{pc: x.a, instr: rd});
         end
         if (redirect) begin
            fifo_m.delete();
            foreach (inf[i]) inf[i].stale = 1'b1;
            m_pc = {redirect_pc[31:2], 2'b00};
         end
         if (gr) begin
            inf.push_back('{a: m_pc, stale: 1'b0});
            memq.push_back('{a: m_pc, due: cyc + 1 + int'($urandom_range(lat_hi, lat_lo))});
            m_pc += 32'd4;
         end
      end
      if (rv) void'(memq.pop_front());
      cyc++;
      #1;
   endtask
   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      int fg, fv, nv, found;
      logic [31:0] held;
      checks = 0; failures = 0; cyc = 0; lat_lo = 0; lat_hi = 0; m_pc = RESET_PC;
      reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
      imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
      @(posedge clk); #1;
      repeat (3) cycle();
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_instr", o_instr, NOP_INSTR);
      chk("rst_pc", o_pc, RESET_PC);
      chk("rst_pc4", o_pc4, RESET_PC + 32'd4);
      chk("rst_req", 32'(o_req), 32'd0);
      // streaming with a 1-cycle memory
      reset = 1'b0; imem.imem_gnt = 1'b1; fg = -1; fv = -1; nv = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (o_req && fg < 0) fg = cyc - 1;
         if (o_valid && fv < 0) begin
            fv = cyc - 1;
            chk("first_pc", o_pc, 32'h0);
            chk("first_instr", o_instr, 32'hA5A5_0000);
            chk("first_pc4", o_pc4, 32'h4);
         end
         if (i >= 10) nv += int'(o_valid);
      end
      chk("first_latency", 32'(fv - fg), 32'd2);
      chk("stream_rate", 32'(nv), 32'd10);
      // stall from reset fills the queue with 0,4,8,12
      reset = 1'b1;
      repeat (2) cycle();
      reset = 1'b0; id_ready = 1'b0;
      repeat (8) cycle();
      chk("stall_req", 32'(o_req), 32'd0);
      chk("stall_head", o_pc, 32'h0);
      id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("release_valid", 32'(o_valid), 32'd1);
         chk("release_pc", o_pc, 32'(4 * i));
      end
      // grant withheld: address holds, queue drains
      cycle();
      imem.imem_gnt = 1'b0; held = '0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (i == 0) held = o_addr;
         else chk("hold_addr", o_addr, held);
      end
      chk("drain_valid", 32'(o_valid), 32'd0);
      chk("drain_instr", o_instr, 32'h0000_0013);
      imem.imem_gnt = 1'b1;
      cycle();
      chk("resume_req", 32'(o_req), 32'd1);
      chk("resume_addr", o_addr, held);
      // redirect with 2 in flight, one response landing in the redirect cycle
      lat_lo = 1; lat_hi = 1; found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (inf.size() == 2 && memq.size() != 0 && memq[0].due <= cyc) found = 1;
         else cycle();
      end
      chk("redir_setup", 32'(found), 32'd1);
      redirect = 1'b1; redirect_pc = 32'h0000_0102;
      cycle();
      chk("redir_req", 32'(o_req), 32'd0);
      chk("redir_drop", 32'(dut.drop_q), 32'd1);
      redirect = 1'b0;
      cycle();
      chk("redir_addr", o_addr, 32'h0000_0100);
      chk("redir_flushed", 32'(o_valid), 32'd0);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         if (o_valid) begin
            found = 1;
            chk("redir_first_pc", o_pc, 32'h0000_0100);
         end
      end
      chk("redir_first_seen", 32'(found), 32'd1);
      // reset mid-stream with 2 in flight; late responses must be ignored
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (inf.size() == 2) found = 1;
         else cycle();
      end
      chk("rst2_setup", 32'(found), 32'd1);
      reset = 1'b1; imem.imem_gnt = 1'b0;
      cycle();
      reset = 1'b0;
      for (int i = 0; i < 10 && memq.size() != 0; i++) cycle();
      cycle();
      chk("rst2_valid", 32'(o_valid), 32'd0);
      chk("rst2_instr", o_instr, NOP_INSTR);
      chk("rst2_pc", o_pc, RESET_PC);
      chk("rst2_pc4", o_pc4, RESET_PC + 32'd4);
      chk("rst2_addr", o_addr, RESET_PC);
      imem.imem_gnt = 1'b1;
      repeat (4) cycle();
      // randomized traffic
      lat_lo = 0; lat_hi = 3;
      for (int i = 0; i < 3000; i++) begin
         imem.imem_gnt = $urandom_range(9, 0) < 7;
         id_ready      = $urandom_range(3, 0) != 0;
         redirect      = $urandom_range(19, 0) == 0;
         redirect_pc   = $urandom;
         cycle();
      end
      redirect = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
